reorder_buffer: RTL

//  In-order retirement queue between dispatch and the architectural register file.

---
 rtl/reorder_buffer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with rename, CDB capture, operand forwarding and flush.
// Optional ROB_PERF_CNT_EN adds commit/flush event counters.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic              disp_has_rd,
  input  logic [4:0]        disp_rd,
  input  logic [4:0]        disp_rs1,
  input  logic [4:0]        disp_rs2,
  input  logic [ADDR_W-1:0] disp_pc,
  output logic [TAG_W-1:0]  disp_tag,
  output logic [DATA_W-1:0] disp_rs1_value,
  output logic              disp_rs1_busy,
  output logic [TAG_W-1:0]  disp_rs1_tag,
  output logic [DATA_W-1:0] disp_rs2_value,
  output logic              disp_rs2_busy,
  output logic [TAG_W-1:0]  disp_rs2_tag,
  output logic [4:0]        rob2reg_rs1_request,
  output logic [4:0]        rob2reg_rs2_request,
  input  logic [DATA_W-1:0] reg2rob_rs1_value,
  input  logic [DATA_W-1:0] reg2rob_rs2_value,
  input  logic [DATA_W-1:0] reg2rob_rs1_rename,
  input  logic [DATA_W-1:0] reg2rob_rs2_rename,
  input  logic              reg2rob_rs1_if_rename,
  input  logic              reg2rob_rs2_if_rename,
  output logic [TAG_W-1:0]  rob2reg_reorder,
  output logic              rob2reg_reserve_enable,
  output logic [4:0]        rob2reg_reserve_rd,
  output logic [TAG_W-1:0]  rob2reg_reserve_reorder,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              wb_mispredict,
  input  logic [ADDR_W-1:0] wb_target,
  output logic              rob2reg_commit_enable,
  output logic [4:0]        rob2reg_commit_des,
  output logic [DATA_W-1:0] rob2reg_commit_value,
  output logic [TAG_W-1:0]  rob2reg_commit_reorder,
  output logic [ADDR_W-1:0] rob2reg_commit_pc,
  output logic              flush_enable,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [TAG_W:0]    rob_count
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_commit_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [TAG_W:0] COUNT_FULL = (TAG_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q, ready_q;
  logic                 has_rd_q  [ROB_DEPTH];
  logic [4:0]           rd_q      [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q   [ROB_DEPTH];
  logic [ADDR_W-1:0]    pc_q      [ROB_DEPTH];
  logic                 mispred_q [ROB_DEPTH];
  logic [ADDR_W-1:0]    target_q  [ROB_DEPTH];

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              commit_en_q, flush_q;
  logic [4:0]        commit_des_q;
  logic [DATA_W-1:0] commit_value_q;
  logic [TAG_W-1:0]  commit_reorder_q;
  logic [ADDR_W-1:0] commit_pc_q, flush_pc_q;

  logic             accept, commit_fire, commit_flush, wb_take;
  logic [TAG_W-1:0] rs1_tag, rs2_tag;
  logic             unused_rename;

  assign unused_rename = ^{reg2rob_rs1_rename[DATA_W-1:TAG_W], reg2rob_rs2_rename[DATA_W-1:TAG_W]};

  assign disp_ready   = (count_q != COUNT_FULL) && !flush_q;
  assign accept       = disp_valid && disp_ready && rdy_in;
  assign commit_fire  = rdy_in && valid_q[head_q] && ready_q[head_q];
  assign commit_flush = commit_fire && mispred_q[head_q];
  assign wb_take      = rdy_in && wb_valid && !flush_q && valid_q[wb_tag];

  assign disp_tag                = tail_q;
  assign rob2reg_reorder         = tail_q;
  assign rob2reg_reserve_enable  = accept && disp_has_rd && (disp_rd != 5'd0);
  assign rob2reg_reserve_rd      = disp_rd;
  assign rob2reg_reserve_reorder = tail_q;
  assign rob2reg_rs1_request     = disp_rs1;
  assign rob2reg_rs2_request     = disp_rs2;

  assign rs1_tag      = reg2rob_rs1_rename[TAG_W-1:0];
  assign rs2_tag      = reg2rob_rs2_rename[TAG_W-1:0];
  assign disp_rs1_tag = rs1_tag;
  assign disp_rs2_tag = rs2_tag;

  // A renamed source resolves from a finished ROB entry, else from the CDB this cycle.
  always_comb begin
    disp_rs1_busy  = 1'b0;
    disp_rs1_value = reg2rob_rs1_value;
    if (reg2rob_rs1_if_rename) begin
      if (ready_q[rs1_tag]) begin
        disp_rs1_value = value_q[rs1_tag];
      end else if (wb_valid && wb_tag == rs1_tag) begin
        disp_rs1_value = wb_value;
      end else begin
        disp_rs1_busy  = 1'b1;
        disp_rs1_value = '0;
      end
    end
  end

  always_comb begin
    disp_rs2_busy  = 1'b0;
    disp_rs2_value = reg2rob_rs2_value;
    if (reg2rob_rs2_if_rename) begin
      if (ready_q[rs2_tag]) begin
        disp_rs2_value = value_q[rs2_tag];
      end else if (wb_valid && wb_tag == rs2_tag) begin
        disp_rs2_value = wb_value;
      end else begin
        disp_rs2_busy  = 1'b1;
        disp_rs2_value = '0;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (commit_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) head_d = head_q + TAG_W'(1);
      if (accept)      tail_d = tail_q + TAG_W'(1);
      count_d = count_q + {{TAG_W{1'b0}}, accept} - {{TAG_W{1'b0}}, commit_fire};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      valid_q          <= '0;
      ready_q          <= '0;
      commit_en_q      <= 1'b0;
      commit_des_q     <= '0;
      commit_value_q   <= '0;
      commit_reorder_q <= '0;
      commit_pc_q      <= '0;
      flush_q          <= 1'b0;
      flush_pc_q       <= '0;
    end else begin
      commit_en_q <= commit_fire;
      flush_q     <= commit_flush;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      if (commit_fire) begin
        commit_des_q     <= has_rd_q[head_q] ? rd_q[head_q] : 5'd0;
        commit_value_q   <= value_q[head_q];
        commit_reorder_q <= head_q;
        commit_pc_q      <= pc_q[head_q];
      end
      if (commit_flush) flush_pc_q <= target_q[head_q];
      if (wb_take) ready_q[wb_tag] <= 1'b1;
      if (commit_flush) begin
        valid_q <= '0;
        ready_q <= '0;
      end else begin
        // ready is kept on retire so renamed readers see the value until the regfile catches up.
        if (commit_fire) valid_q[head_q] <= 1'b0;
        if (accept) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      has_rd_q[tail_q]  <= disp_has_rd;
      rd_q[tail_q]      <= disp_rd;
      pc_q[tail_q]      <= disp_pc;
      mispred_q[tail_q] <= 1'b0;
    end
    if (wb_take) begin
      value_q[wb_tag]   <= wb_value;
      mispred_q[wb_tag] <= wb_mispredict;
      target_q[wb_tag]  <= wb_target;
    end
  end

  assign rob2reg_commit_enable  = commit_en_q;
  assign rob2reg_commit_des     = commit_des_q;
  assign rob2reg_commit_value   = commit_value_q;
  assign rob2reg_commit_reorder = commit_reorder_q;
  assign rob2reg_commit_pc      = commit_pc_q;
  assign flush_enable           = flush_q;
  assign flush_pc               = flush_pc_q;
  assign rob_count              = count_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_flush_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_commit_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (commit_fire)  perf_commit_q <= perf_commit_q + 32'd1;
      if (commit_flush) perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end

  assign perf_commit_cnt = perf_commit_q;
  assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule
